// File: rtl/uart_loader.sv
// UART boot loader: receives a length-prefixed 8N1 image, writes 32-bit LE words into imem, then releases the core.
// Optional trailing XOR checksum byte: define UART_LOADER_CHECKSUM_EN.
module uart_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 8,
  parameter int DEPTH_WORDS  = 256
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0]      DEPTH_LEN = 16'(DEPTH_WORDS);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

`ifdef UART_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {LD_LEN0, LD_LEN1, LD_DATA, LD_CSUM, LD_DONE, LD_ERR} ld_state_t;
  localparam ld_state_t LD_TAIL = LD_CSUM;
`else
  typedef enum logic [2:0] {LD_LEN0, LD_LEN1, LD_DATA, LD_DONE, LD_ERR} ld_state_t;
  localparam ld_state_t LD_TAIL = LD_DONE;
`endif

  logic r_rx_meta, r_rx_sync, r_rx_prev;

  rx_state_t        r_rx_state, w_rx_nxt;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_byte_valid, r_frame_err, r_started;
  logic             w_start_ok, w_bit_take, w_stop_ok, w_stop_bad;

  ld_state_t        r_ld_state, w_ld_nxt;
  logic [15:0]      r_len;
  logic [15:0]      w_len_full;
  logic [1:0]       r_byte_cnt;
  logic [23:0]      r_word;
  logic             r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [31:0]      r_wdata;
  logic             w_wr_last;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]       r_csum;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  always_comb begin
    w_rx_nxt   = r_rx_state;
    w_start_ok = 1'b0;
    w_bit_take = 1'b0;
    w_stop_ok  = 1'b0;
    w_stop_bad = 1'b0;
    case (r_rx_state)
      RX_IDLE: if (r_rx_prev && !r_rx_sync) w_rx_nxt = RX_START;
      RX_START: begin
        // Mid-bit recheck rejects glitches shorter than half a bit.
        if (r_clk_cnt == CNT_HALF) begin
          if (r_rx_sync) begin
            w_rx_nxt = RX_IDLE;
          end else begin
            w_rx_nxt   = RX_DATA;
            w_start_ok = 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (r_clk_cnt == CNT_FULL) begin
          w_bit_take = 1'b1;
          if (r_bit_idx == 3'd7) w_rx_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (r_clk_cnt == CNT_FULL) begin
          w_rx_nxt   = RX_IDLE;
          w_stop_ok  = r_rx_sync;
          w_stop_bad = !r_rx_sync;
        end
      end
      default: w_rx_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rx_state   <= RX_IDLE;
      r_clk_cnt    <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_started    <= 1'b0;
    end else begin
      r_rx_state   <= w_rx_nxt;
      r_byte_valid <= w_stop_ok;
      r_frame_err  <= w_stop_bad;
      if (w_rx_nxt != r_rx_state || w_bit_take || r_rx_state == RX_IDLE)
        r_clk_cnt <= '0;
      else
        r_clk_cnt <= r_clk_cnt + 1'b1;
      if (w_start_ok) begin
        r_bit_idx <= '0;
        r_started <= 1'b1;
      end
      if (w_bit_take) begin
        r_shift   <= {r_rx_sync, r_shift[7:1]};
        r_bit_idx <= r_bit_idx + 1'b1;
      end
    end
  end

  assign w_len_full = {r_shift, r_len[7:0]};
  assign w_wr_last  = (16'(r_waddr) == r_len - 16'd1);

  always_comb begin
    w_ld_nxt = r_ld_state;
    case (r_ld_state)
      LD_LEN0: begin
        if (r_frame_err)       w_ld_nxt = LD_ERR;
        else if (r_byte_valid) w_ld_nxt = LD_LEN1;
      end
      LD_LEN1: begin
        if (r_frame_err) begin
          w_ld_nxt = LD_ERR;
        end else if (r_byte_valid) begin
          if (w_len_full == 16'd0)           w_ld_nxt = LD_TAIL;
          else if (w_len_full > DEPTH_LEN)   w_ld_nxt = LD_ERR;
          else                               w_ld_nxt = LD_DATA;
        end
      end
      LD_DATA: begin
        if (r_frame_err)            w_ld_nxt = LD_ERR;
        else if (r_we && w_wr_last) w_ld_nxt = LD_TAIL;
      end
`ifdef UART_LOADER_CHECKSUM_EN
      LD_CSUM: begin
        if (r_frame_err)       w_ld_nxt = LD_ERR;
        else if (r_byte_valid) w_ld_nxt = (r_shift == r_csum) ? LD_DONE : LD_ERR;
      end
`endif
      default: w_ld_nxt = r_ld_state;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_ld_state <= LD_LEN0;
      r_len      <= '0;
      r_byte_cnt <= '0;
      r_word     <= '0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      r_ld_state <= w_ld_nxt;
      r_we       <= 1'b0;
      if (r_byte_valid) begin
        case (r_ld_state)
          LD_LEN0: r_len[7:0]  <= r_shift;
          LD_LEN1: r_len[15:8] <= r_shift;
          LD_DATA: begin
            r_byte_cnt <= r_byte_cnt + 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
            r_csum     <= r_csum ^ r_shift;
`endif
            case (r_byte_cnt)
              2'd0: r_word[7:0]   <= r_shift;
              2'd1: r_word[15:8]  <= r_shift;
              2'd2: r_word[23:16] <= r_shift;
              default: begin
                r_we    <= 1'b1;
                r_wdata <= {r_shift, r_word};
              end
            endcase
          end
          default: ;
        endcase
      end
      // Address holds on the final word so a full-depth image never wraps it.
      if (r_we && !w_wr_last) r_waddr <= r_waddr + 1'b1;
    end
  end

  assign imem_we    = r_we;
  assign imem_waddr = r_waddr;
  assign imem_wdata = r_wdata;
  assign done       = (r_ld_state == LD_DONE);
  assign err        = (r_ld_state == LD_ERR);
  assign core_rst   = !done;
  assign busy       = r_started && !done && !err;

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader (CLKS_PER_BIT=4, DEPTH_WORDS=16); honours UART_LOADER_CHECKSUM_EN.
module tb_uart_loader;
  localparam int CPB = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        rx  = 1'b1;
  logic        imem_we;
  logic [7:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        core_rst, busy, done, err;

  uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(8), .DEPTH_WORDS(16)) dut (
    .CLK(CLK), .RST(RST), .rx(rx),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .core_rst(core_rst), .busy(busy), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;

  int          wr_cnt = 0;
  logic [7:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;

  always @(negedge CLK) begin
    if (!RST) begin
      wr_cnt  = 0;
      wr_addr = '0;
      wr_data = '0;
    end else if (imem_we) begin
      wr_cnt  = wr_cnt + 1;
      wr_addr = imem_waddr;
      wr_data = imem_wdata;
    end
  end

  typedef struct {
    bit          glitch;
    bit          rst;
    logic [7:0]  data;
    bit          stop;
    bit          e_busy;
    bit          e_done;
    bit          e_err;
    int          e_wcnt;
    logic [7:0]  e_waddr;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t vt[$];

  function automatic void add(bit g, bit r, logic [7:0] d, bit s, bit b, bit dn, bit e,
                              int wc, logic [7:0] wa, logic [31:0] wd);
    vec_t v;
    v.glitch = g; v.rst = r; v.data = d; v.stop = s;
    v.e_busy = b; v.e_done = dn; v.e_err = e;
    v.e_wcnt = wc; v.e_waddr = wa; v.e_wdata = wd;
    vt.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b0;
    rx  = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic send_byte(input logic [7:0] d, input bit stop, input int idle_bits);
    rx = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge CLK);
    end
    rx = stop;
    repeat (CPB) @(negedge CLK);
    rx = 1'b1;
    repeat (idle_bits * CPB) @(negedge CLK);
  endtask

  task automatic glitch();
    rx = 1'b0;
    repeat (CPB / 2) @(negedge CLK);
    rx = 1'b1;
    repeat (12 * CPB) @(negedge CLK);
  endtask

  initial begin
    string tag;
    bit    seen;

    // Two-word image
    add(0,1,8'h02,1, 1,0,0, 0,8'h00,32'h0);
    add(0,0,8'h00,1, 1,0,0, 0,8'h00,32'h0);
    add(0,0,8'h13,1, 1,0,0, 0,8'h00,32'h0);
    add(0,0,8'h00,1, 1,0,0, 0,8'h00,32'h0);
    add(0,0,8'h00,1, 1,0,0, 0,8'h00,32'h0);
    add(0,0,8'h00,1, 1,0,0, 1,8'h00,32'h00000013);
    add(0,0,8'h93,1, 1,0,0, 1,8'h00,32'h00000013);
    add(0,0,8'h00,1, 1,0,0, 1,8'h00,32'h00000013);
    add(0,0,8'h10,1, 1,0,0, 1,8'h00,32'h00000013);
`ifdef UART_LOADER_CHECKSUM_EN
    add(0,0,8'h00,1, 1,0,0, 2,8'h01,32'h00100093);
    add(0,0,8'h90,1, 0,1,0, 2,8'h01,32'h00100093);
`else
    add(0,0,8'h00,1, 0,1,0, 2,8'h01,32'h00100093);
`endif
    // Zero-length image
    add(0,1,8'h00,1, 1,0,0, 0,8'h00,32'h0);
`ifdef UART_LOADER_CHECKSUM_EN
    add(0,0,8'h00,1, 1,0,0, 0,8'h00,32'h0);
    add(0,0,8'h00,1, 0,1,0, 0,8'h00,32'h0);
`else
    add(0,0,8'h00,1, 0,1,0, 0,8'h00,32'h0);
`endif
    // Oversize length 17
    add(0,1,8'h11,1, 1,0,0, 0,8'h00,32'h0);
    add(0,0,8'h00,1, 0,0,1, 0,8'h00,32'h0);
    // Exactly full depth is accepted
    add(0,1,8'h10,1, 1,0,0, 0,8'h00,32'h0);
    add(0,0,8'h00,1, 1,0,0, 0,8'h00,32'h0);
    // Framing error in data, later bytes ignored
    add(0,1,8'h01,1, 1,0,0, 0,8'h00,32'h0);
    add(0,0,8'h00,1, 1,0,0, 0,8'h00,32'h0);
    add(0,0,8'h55,0, 0,0,1, 0,8'h00,32'h0);
    add(0,0,8'h13,1, 0,0,1, 0,8'h00,32'h0);
    add(0,0,8'h00,1, 0,0,1, 0,8'h00,32'h0);
    add(0,0,8'h00,1, 0,0,1, 0,8'h00,32'h0);
    add(0,0,8'h00,1, 0,0,1, 0,8'h00,32'h0);
    // Idle glitch, then a real byte still received
    add(1,1,8'h00,1, 0,0,0, 0,8'h00,32'h0);
    add(0,0,8'h05,1, 1,0,0, 0,8'h00,32'h0);
    add(0,0,8'h00,1, 1,0,0, 0,8'h00,32'h0);

    RST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst.we",       32'(imem_we),    32'h0);
    chk("rst.waddr",    32'(imem_waddr), 32'h0);
    chk("rst.wdata",    imem_wdata,      32'h0);
    chk("rst.core_rst", 32'(core_rst),   32'h1);
    chk("rst.busy",     32'(busy),       32'h0);
    chk("rst.done",     32'(done),       32'h0);
    chk("rst.err",      32'(err),        32'h0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].rst) do_reset();
      if (vt[i].glitch) glitch();
      else send_byte(vt[i].data, vt[i].stop, 2);
      tag = $sformatf("v%0d", i);
      chk({tag, ".busy"},     32'(busy),     32'(vt[i].e_busy));
      chk({tag, ".done"},     32'(done),     32'(vt[i].e_done));
      chk({tag, ".err"},      32'(err),      32'(vt[i].e_err));
      chk({tag, ".core_rst"}, 32'(core_rst), 32'(!vt[i].e_done));
      chk({tag, ".wcnt"},     32'(wr_cnt),   32'(vt[i].e_wcnt));
      chk({tag, ".waddr"},    32'(wr_addr),  32'(vt[i].e_waddr));
      chk({tag, ".wdata"},    wr_data,       vt[i].e_wdata);
    end

    // Reset mid-word, then a clean one-word image with cycle-level release timing
    do_reset();
    send_byte(8'h01, 1'b1, 2);
    send_byte(8'h00, 1'b1, 2);
    send_byte(8'hEF, 1'b1, 2);
    send_byte(8'hBE, 1'b1, 2);
    chk("mid.busy", 32'(busy), 32'h1);
    do_reset();
    chk("mid.rst_busy",     32'(busy),       32'h0);
    chk("mid.rst_core_rst", 32'(core_rst),   32'h1);
    chk("mid.rst_waddr",    32'(imem_waddr), 32'h0);
    chk("mid.rst_wdata",    imem_wdata,      32'h0);
    send_byte(8'h01, 1'b1, 2);
    send_byte(8'h00, 1'b1, 2);
    send_byte(8'hEF, 1'b1, 2);
    send_byte(8'hBE, 1'b1, 2);
    send_byte(8'hAD, 1'b1, 2);
    send_byte(8'hDE, 1'b1, 0);
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge CLK);
      if (imem_we) seen = 1'b1;
    end
    chk("one.we_seen", 32'(seen), 32'h1);
    if (seen) begin
      chk("one.waddr",      32'(imem_waddr), 32'h0);
      chk("one.wdata",      imem_wdata,      32'hDEADBEEF);
      chk("one.done_at_we", 32'(done),       32'h0);
      @(negedge CLK);
      chk("one.we_pulse",   32'(imem_we),    32'h0);
`ifdef UART_LOADER_CHECKSUM_EN
      chk("one.done_pre",   32'(done),       32'h0);
      send_byte(8'h22, 1'b1, 2);
`endif
      chk("one.done",       32'(done),       32'h1);
      chk("one.core_rst",   32'(core_rst),   32'h0);
      chk("one.busy",       32'(busy),       32'h0);
      chk("one.err",        32'(err),        32'h0);
    end
    repeat (2) @(negedge CLK);
    chk("one.wcnt", 32'(wr_cnt), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
